// File: rtl/fifo_prefetch_reader.sv
// Read-side companion for small_async_fifo: prefetches words into a two-entry
// buffer and presents them as a registered valid/ready stream with a word counter.
module fifo_prefetch_reader #(
  parameter int WIDTH     = 72,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 enable,
  input  logic                 fifo_rempty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_rinc,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] words_out,
  output logic                 busy
);

  logic [1:0]           occ_q, occ_d;
  logic                 infl_q;
  logic [WIDTH-1:0]     slot0_q, slot0_d;
  logic [WIDTH-1:0]     slot1_q, slot1_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;
  logic                 pop;
  logic [2:0]           credit;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = slot0_q;
  assign words_out = words_q;
  assign busy      = out_valid | infl_q;
  assign pop       = out_valid & out_ready;

  // Occupancy after this cycle if nothing new arrives; the combinational
  // out_ready -> fifo_rinc path lets a pop free a slot for a read in the same cycle.
  assign credit    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign fifo_rinc = rrst_n & enable & ~fifo_rempty & (credit < 3'd2);

  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    words_d = words_q + CNT_WIDTH'(pop);
    if (infl_q) begin
      unique case (occ_q)
        2'd0: begin
          slot0_d = fifo_rdata;
          occ_d   = 2'd1;
        end
        2'd1: begin
          if (pop) begin
            slot0_d = fifo_rdata;
          end else begin
            slot1_d = fifo_rdata;
            occ_d   = 2'd2;
          end
        end
        default: begin
          slot0_d = slot1_q;
          slot1_d = fifo_rdata;
          occ_d   = 2'd2;
        end
      endcase
    end else if (pop) begin
      slot0_d = slot1_q;
      occ_d   = occ_q - 2'd1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q   <= 2'd0;
      infl_q  <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
      words_q <= '0;
    end else begin
      occ_q   <= occ_d;
      infl_q  <= fifo_rinc;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      words_q <= words_d;
    end
  end

  // The credit rule guarantees a returning word always finds a free slot.
  noOverflowOnReturn: assert property (@(posedge rclk) disable iff (!rrst_n)
    !(infl_q && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_prefetch_reader.sv
// Self-checking bench for fifo_prefetch_reader: a queue-style FIFO model feeds the
// DUT and each scenario compares the delivered stream against the words it pushed.
module tb_fifo_prefetch_reader;

  localparam int W  = 72;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          enable;
  logic          fifo_rempty;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_rinc;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] words_out;
  logic          busy;

  fifo_prefetch_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .enable      (enable),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .words_out   (words_out),
    .busy        (busy)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  // FIFO model: bench pushes at wrPtr, reads pop at rdPtr; data is registered.
  logic [W-1:0] mem [0:511];
  int wrPtr = 0;
  int rdPtr = 0;
  int rincCount = 0;
  int rincLast = -1;
  int emptyReadViol = 0;
  int cycleNo = 0;

  assign fifo_rempty = (wrPtr == rdPtr);

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdPtr      <= wrPtr;
      fifo_rdata <= '0;
    end else if (fifo_rinc) begin
      if (wrPtr == rdPtr) emptyReadViol <= emptyReadViol + 1;
      fifo_rdata <= mem[rdPtr];
      rdPtr      <= rdPtr + 1;
      rincCount  <= rincCount + 1;
      rincLast   <= cycleNo;
    end
  end

  // Stream observations gathered by stepCycle.
  logic [W-1:0] gotQ [$];
  int           popCycles [$];
  int           validCycles;
  int           stabViol;
  logic         prevValid, prevReady;
  logic [W-1:0] prevData;
  logic [CW-1:0] expWords = '0;

  task automatic pushWord(input logic [W-1:0] w);
    mem[wrPtr] = w;
    wrPtr = wrPtr + 1;
  endtask

  task automatic clearObs();
    gotQ.delete();
    popCycles.delete();
    validCycles = 0;
    stabViol = 0;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevData = '0;
  endtask

  task automatic stepCycle(input logic rdy);
    @(negedge rclk);
    cycleNo = cycleNo + 1;
    if (prevValid && !prevReady && (!out_valid || out_data !== prevData)) stabViol++;
    if (out_valid) validCycles++;
    out_ready = rdy;
    if (out_valid && rdy) begin
      gotQ.push_back(out_data);
      popCycles.push_back(cycleNo);
    end
    prevValid = out_valid;
    prevReady = rdy;
    prevData = out_data;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge rclk);
    pushWord(72'h77);
    #1;
    checks++; if (fifo_rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b expected 0", fifo_rinc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    checks++; if (words_out !== '0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge rclk);
    rrst_n = 1'b1;
    clearObs();
    repeat (4) stepCycle(1'b1);
    checks++; if (validCycles != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: valid cycles %0d busy %b expected 0/0", validCycles, busy); end
  endtask

  task automatic test_single();
    int base;
    clearObs();
    base = rincCount;
    pushWord(72'h0A5);
    repeat (8) stepCycle(1'b1);
    expWords = expWords + 1;
    checks++; if (rincCount - base != 1) begin errors++; $display("FAIL single_rinc: got %0d pulses expected 1", rincCount - base); end
    checks++; if (validCycles != 1) begin errors++; $display("FAIL single_validlen: got %0d cycles expected 1", validCycles); end
    checks++; if (gotQ.size() != 1 || gotQ[0] !== 72'h0A5) begin errors++; $display("FAIL single_data: got %0d words first %0h expected 0a5", gotQ.size(), gotQ[0]); end
    checks++; if (popCycles.size() != 1 || popCycles[0] != rincLast + 2) begin errors++; $display("FAIL single_latency: valid at %0d expected %0d", popCycles[0], rincLast + 2); end
    checks++; if (words_out !== expWords) begin errors++; $display("FAIL single_words: got %0d expected %0d", words_out, expWords); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_burst();
    int base;
    clearObs();
    base = rincCount;
    for (int i = 1; i <= 8; i++) pushWord(W'(i));
    repeat (16) stepCycle(1'b1);
    expWords = expWords + 8;
    checks++; if (gotQ.size() != 8) begin errors++; $display("FAIL burst_count: got %0d expected 8", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < 8; i++) begin
      checks++; if (gotQ[i] !== W'(i + 1)) begin errors++; $display("FAIL burst_data[%0d]: got %0h expected %0h", i, gotQ[i], i + 1); end
    end
    checks++; if (popCycles.size() != 8 || popCycles[7] - popCycles[0] != 7) begin errors++; $display("FAIL burst_gapless: got %0d words over span %0d expected 8 over 7", popCycles.size(), popCycles[popCycles.size()-1] - popCycles[0]); end
    checks++; if (rincCount - base != 8) begin errors++; $display("FAIL burst_rinc: got %0d expected 8", rincCount - base); end
    checks++; if (words_out !== expWords) begin errors++; $display("FAIL burst_words: got %0d expected %0d", words_out, expWords); end
  endtask

  task automatic test_backpressure();
    int base;
    clearObs();
    base = rincCount;
    for (int i = 1; i <= 8; i++) pushWord(W'(i));
    repeat (10) stepCycle(1'b0);
    checks++; if (rincCount - base != 2) begin errors++; $display("FAIL bp_rinc: got %0d expected 2", rincCount - base); end
    checks++; if (out_valid !== 1'b1 || out_data !== W'(1)) begin errors++; $display("FAIL bp_head: got valid %b data %0h expected 1/1", out_valid, out_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
    repeat (14) stepCycle(1'b1);
    expWords = expWords + 8;
    checks++; if (stabViol != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stabViol); end
    checks++; if (gotQ.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < 8; i++) begin
      checks++; if (gotQ[i] !== W'(i + 1)) begin errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, gotQ[i], i + 1); end
    end
    checks++; if (popCycles.size() != 8 || popCycles[7] - popCycles[0] != 7) begin errors++; $display("FAIL bp_gapless: got %0d words expected 8 with no gap", popCycles.size()); end
    checks++; if (words_out !== expWords) begin errors++; $display("FAIL bp_words: got %0d expected %0d", words_out, expWords); end
  endtask

  task automatic test_toggle();
    clearObs();
    for (int i = 0; i < 16; i++) pushWord(W'(72'h100 + i));
    for (int c = 0; c < 48; c++) stepCycle(c[0]);
    repeat (4) stepCycle(1'b1);
    expWords = expWords + 16;
    checks++; if (gotQ.size() != 16) begin errors++; $display("FAIL toggle_count: got %0d expected 16", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < 16; i++) begin
      checks++; if (gotQ[i] !== W'(72'h100 + i)) begin errors++; $display("FAIL toggle_data[%0d]: got %0h expected %0h", i, gotQ[i], 72'h100 + i); end
    end
    checks++; if (stabViol != 0) begin errors++; $display("FAIL toggle_stable: got %0d violations expected 0", stabViol); end
    checks++; if (words_out !== expWords) begin errors++; $display("FAIL toggle_words: got %0d expected %0d", words_out, expWords); end
  endtask

  task automatic test_enable();
    int base;
    int guard;
    clearObs();
    base = rincCount;
    guard = 0;
    for (int i = 1; i <= 6; i++) pushWord(W'(72'h200 + i));
    while (rincCount - base < 3 && guard < 20) begin
      stepCycle(1'b1);
      guard++;
    end
    enable = 1'b0;
    repeat (10) stepCycle(1'b1);
    checks++; if (guard >= 20) begin errors++; $display("FAIL enable_timeout: got %0d reads expected 3", rincCount - base); end
    checks++; if (rincCount - base != 3) begin errors++; $display("FAIL enable_rinc: got %0d expected 3", rincCount - base); end
    checks++; if (gotQ.size() != 3 || gotQ[2] !== W'(72'h203)) begin errors++; $display("FAIL enable_drain: got %0d words last %0h expected 3 last 203", gotQ.size(), gotQ[gotQ.size()-1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_busy: got %b expected 0", busy); end
    enable = 1'b1;
    repeat (10) stepCycle(1'b1);
    expWords = expWords + 6;
    checks++; if (gotQ.size() != 6) begin errors++; $display("FAIL enable_resume_count: got %0d expected 6", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < 6; i++) begin
      checks++; if (gotQ[i] !== W'(72'h201 + i)) begin errors++; $display("FAIL enable_data[%0d]: got %0h expected %0h", i, gotQ[i], 72'h201 + i); end
    end
    checks++; if (words_out !== expWords) begin errors++; $display("FAIL enable_words: got %0d expected %0d", words_out, expWords); end
  endtask

  task automatic test_random();
    logic [W-1:0] expQ [$];
    logic [W-1:0] w;
    int guard;
    clearObs();
    guard = 0;
    while (gotQ.size() < 40 && guard < 2000) begin
      stepCycle(1'($urandom_range(0, 1)));
      enable = ($urandom_range(0, 4) != 0);
      if (expQ.size() < 40 && $urandom_range(0, 2) == 0) begin
        w = {$urandom, $urandom, $urandom};
        expQ.push_back(w);
        pushWord(w);
      end
      guard++;
    end
    enable = 1'b1;
    repeat (4) stepCycle(1'b1);
    expWords = expWords + 6'd40;
    checks++; if (guard >= 2000) begin errors++; $display("FAIL random_timeout: got %0d words expected 40", gotQ.size()); end
    checks++; if (gotQ.size() != 40) begin errors++; $display("FAIL random_count: got %0d expected 40", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("FAIL random_data[%0d]: got %0h expected %0h", i, gotQ[i], expQ[i]); end
    end
    checks++; if (stabViol != 0) begin errors++; $display("FAIL random_stable: got %0d violations expected 0", stabViol); end
    checks++; if (emptyReadViol != 0) begin errors++; $display("FAIL random_empty_read: got %0d expected 0", emptyReadViol); end
    checks++; if (words_out !== expWords || busy !== 1'b0) begin errors++; $display("FAIL random_words: got %0d busy %b expected %0d busy 0", words_out, busy, expWords); end
  endtask

  task automatic test_midreset();
    clearObs();
    for (int i = 1; i <= 8; i++) pushWord(W'(72'h300 + i));
    repeat (6) stepCycle(1'b0);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midreset_loaded: got valid %b busy %b expected 1/1", out_valid, busy); end
    #2 rrst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || fifo_rinc !== 1'b0) begin errors++; $display("FAIL midreset_clear: got valid %b data %0h busy %b rinc %b expected all 0", out_valid, out_data, busy, fifo_rinc); end
    checks++; if (words_out !== '0) begin errors++; $display("FAIL midreset_words: got %0d expected 0", words_out); end
    @(negedge rclk);
    rrst_n = 1'b1;
    clearObs();
    repeat (5) stepCycle(1'b1);
    checks++; if (validCycles != 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles expected 0", validCycles); end
    pushWord(72'h3C);
    repeat (6) stepCycle(1'b1);
    expWords = 1;
    checks++; if (gotQ.size() != 1 || gotQ[0] !== W'(72'h3C)) begin errors++; $display("FAIL midreset_new: got %0d words first %0h expected 1 word 3c", gotQ.size(), gotQ[0]); end
    checks++; if (words_out !== expWords) begin errors++; $display("FAIL midreset_restart: got %0d expected %0d", words_out, expWords); end
  endtask

  task automatic test_wrap();
    clearObs();
    for (int i = 0; i < 14; i++) pushWord(W'(72'h400 + i));
    repeat (20) stepCycle(1'b1);
    expWords = expWords + 14;
    checks++; if (words_out !== expWords || expWords != 15) begin errors++; $display("FAIL wrap_pre: got %0d expected 15", words_out); end
    pushWord(72'h4FF);
    repeat (6) stepCycle(1'b1);
    expWords = expWords + 1;
    checks++; if (words_out !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", words_out); end
    checks++; if (gotQ.size() != 15 || gotQ[14] !== W'(72'h4FF)) begin errors++; $display("FAIL wrap_data: got %0d words last %0h expected 15 last 4ff", gotQ.size(), gotQ[gotQ.size()-1]); end
  endtask

  initial begin
    out_ready = 1'b0;
    enable = 1'b0;
    rrst_n = 1'b1;
    #1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_toggle();
    test_enable();
    test_random();
    test_midreset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
